// File: rtl/knight_pkg.sv
// rtl/knight_pkg.sv - knight move constants, sequencer states and move-offset decode
package knight_pkg;

    localparam logic [3:0] OP_MOVE     = 4'h4;
    localparam logic [3:0] OP_FANFARE  = 4'h5;

    localparam logic [7:0] HDG_NORTH   = 8'h00;
    localparam logic [7:0] HDG_WEST    = 8'h3F;
    localparam logic [7:0] HDG_SOUTH   = 8'h7F;
    localparam logic [7:0] HDG_EAST    = 8'hBF;

    localparam logic [7:0] RESP_DONE   = 8'hA5;
    localparam logic [7:0] RESP_BUSY   = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VERT,
        ST_HOLD_V,
        ST_HORZ,
        ST_HOLD_H
    } state_e;

    typedef struct packed {
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } offset_t;

    // +x is east, +y is north; anything that is not one-hot yields a null offset
    function automatic offset_t decode_move(input logic [7:0] move);
        offset_t o;
        o.dx = 3'sd0;
        o.dy = 3'sd0;
        case (move)
            8'h01: begin o.dx =  3'sd1; o.dy =  3'sd2; end
            8'h02: begin o.dx = -3'sd1; o.dy =  3'sd2; end
            8'h04: begin o.dx = -3'sd2; o.dy =  3'sd1; end
            8'h08: begin o.dx = -3'sd2; o.dy = -3'sd1; end
            8'h10: begin o.dx = -3'sd1; o.dy = -3'sd2; end
            8'h20: begin o.dx =  3'sd1; o.dy = -3'sd2; end
            8'h40: begin o.dx =  3'sd2; o.dy = -3'sd1; end
            8'h80: begin o.dx =  3'sd2; o.dy =  3'sd1; end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/tour_cmd_seq_if.sv
// rtl/tour_cmd_seq_if.sv - command mux handshake bus between UART, sequencer and command processor
interface tour_cmd_seq_if;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );

    modport slave (
        output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_cmd_seq_move_decode.sv
// rtl/tour_cmd_seq_move_decode.sv - one-hot knight move to vertical and horizontal motion commands
module move_decode
    import knight_pkg::*;
(
    input  logic [7:0]  move_i,
    output logic [15:0] vert_cmd_o,
    output logic [15:0] horz_cmd_o
);

    offset_t    ofs;
    logic [2:0] abs_dx;
    logic [2:0] abs_dy;
    logic [7:0] horz_hdg;

    assign ofs    = decode_move(move_i);
    assign abs_dx = ofs.dx[2] ? 3'(-ofs.dx) : 3'(ofs.dx);
    assign abs_dy = ofs.dy[2] ? 3'(-ofs.dy) : 3'(ofs.dy);

    // a zero horizontal leg (invalid move) points north rather than west
    assign horz_hdg = ofs.dx[2]        ? HDG_WEST :
                      (ofs.dx != 3'sd0) ? HDG_EAST : HDG_NORTH;

    assign vert_cmd_o = {OP_MOVE, ofs.dy[2] ? HDG_SOUTH : HDG_NORTH, 1'b0, abs_dy};
    assign horz_cmd_o = {OP_FANFARE, horz_hdg, 1'b0, abs_dx};

endmodule

// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - replays solved knight's tour as motion commands, muxed with UART commands
module tour_cmd_seq
    import knight_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_tour,
    input  logic [7:0]      move,
    output logic [4:0]      mv_indx,
    tour_cmd_seq_if.master  bus
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    state_e      state_q, state_d;
    logic [4:0]  indx_q, indx_d;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;
    logic        last_move;

    move_decode u_move_decode (
        .move_i     (move),
        .vert_cmd_o (vert_cmd),
        .horz_cmd_o (horz_cmd)
    );

    assign mv_indx   = indx_q;
    assign last_move = (indx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            indx_q  <= '0;
        end else begin
            state_q <= state_d;
            indx_q  <= indx_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        indx_d               = indx_q;
        bus.cmd              = bus.cmd_UART;
        bus.cmd_rdy          = 1'b0;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp             = RESP_BUSY;
        case (state_q)
            ST_IDLE: begin
                bus.cmd_rdy          = bus.cmd_rdy_UART;
                bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
                bus.resp             = RESP_DONE;
                if (start_tour) begin
                    indx_d  = '0;
                    state_d = ST_VERT;
                end
            end
            ST_VERT: begin
                bus.cmd     = vert_cmd;
                bus.cmd_rdy = 1'b1;
                if (bus.clr_cmd_rdy) state_d = ST_HOLD_V;
            end
            ST_HOLD_V: begin
                bus.cmd = vert_cmd;
                if (bus.send_resp) state_d = ST_HORZ;
            end
            ST_HORZ: begin
                bus.cmd     = horz_cmd;
                bus.cmd_rdy = 1'b1;
                if (bus.clr_cmd_rdy) state_d = ST_HOLD_H;
            end
            ST_HOLD_H: begin
                bus.cmd = horz_cmd;
                if (last_move) bus.resp = RESP_DONE;
                if (bus.send_resp) begin
                    if (last_move) begin
                        state_d = ST_IDLE;
                    end else begin
                        indx_d  = indx_q + 5'd1;
                        state_d = ST_VERT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb/tb_tour_cmd_seq.sv - scoreboard bench for the knight's-tour command sequencer
module tb_tour_cmd_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_tour;
    logic [7:0] move;
    logic [4:0] mv_indx;

    always #10 clk = ~clk;

    tour_cmd_seq_if bus();

    tour_cmd_seq #(.NUM_MOVES(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_tour (start_tour),
        .move       (move),
        .mv_indx    (mv_indx),
        .bus        (bus)
    );

    logic [7:0] tbl [0:31];
    always_comb move = tbl[mv_indx];

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [15:0] exp_q[$];
    int          idx_log[$];
    int          hs_cnt    = 0;
    int          rise_cnt  = 0;
    logic        rdy_prev  = 1'b0;
    bit          tour_mode = 1'b0;
    bit          cp_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [15:0] exp_v(input logic [7:0] m);
        case (m)
            8'h01: return 16'h4002;
            8'h02: return 16'h4002;
            8'h04: return 16'h4001;
            8'h08: return 16'h47F1;
            8'h10: return 16'h47F2;
            8'h20: return 16'h47F2;
            8'h40: return 16'h47F1;
            8'h80: return 16'h4001;
            default: return 16'h4000;
        endcase
    endfunction

    function automatic logic [15:0] exp_h(input logic [7:0] m);
        case (m)
            8'h01: return 16'h5BF1;
            8'h02: return 16'h53F1;
            8'h04: return 16'h53F2;
            8'h08: return 16'h53F2;
            8'h10: return 16'h53F1;
            8'h20: return 16'h5BF1;
            8'h40: return 16'h5BF2;
            8'h80: return 16'h5BF2;
            default: return 16'h5000;
        endcase
    endfunction

    // Monitor: every accepted handshake pops one expected command
    always @(negedge clk) begin
        if (bus.cmd_rdy && !rdy_prev) rise_cnt++;
        rdy_prev = bus.cmd_rdy;
        if (bus.cmd_rdy && bus.clr_cmd_rdy) begin
            hs_cnt++;
            if (tour_mode && bus.cmd[15:12] == 4'h4) idx_log.push_back(int'(mv_indx));
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected actual=%0h required=none", bus.cmd);
            end else begin
                check("sb_cmd", {16'h0, bus.cmd}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // Command-processor model used for the free-running tour
    initial begin
        forever begin
            @(posedge clk); #1;
            if (cp_en && bus.cmd_rdy) begin
                bus.clr_cmd_rdy = 1'b1;
                @(posedge clk); #1;
                bus.clr_cmd_rdy = 1'b0;
                @(posedge clk); #1;
                bus.send_resp = 1'b1;
                @(posedge clk); #1;
                bus.send_resp = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start_tour = 1'b1; tick(); start_tour = 1'b0;
    endtask

    task automatic leg();
        int n = 0;
        while (!bus.cmd_rdy && n < 50) begin tick(); n++; end
        if (!bus.cmd_rdy) begin
            total_cnt++;
            $display("FAIL leg_rdy actual=timeout required=cmd_rdy");
        end
        bus.clr_cmd_rdy = 1'b1; tick(); bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b1; tick(); bus.send_resp   = 1'b0;
    endtask

    task automatic do_move(input int i);
        check("mv_indx_step", mv_indx, i);
        exp_q.push_back(exp_v(tbl[i]));
        exp_q.push_back(exp_h(tbl[i]));
        leg();
        leg();
    endtask

    initial begin
        int n;
        int stray;
        int bad;
        for (int i = 0; i < 32; i++) tbl[i] = (i < 24) ? (8'h01 << (i % 8)) : 8'h00;
        tbl[15] = 8'h03;
        tbl[23] = 8'h00;
        rst_n = 1'b0; start_tour = 1'b0;
        bus.cmd_UART = 16'h0; bus.cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // reset state and IDLE pass-through
        check("rst_resp", bus.resp, 8'hA5);
        check("rst_mv_indx", mv_indx, 0);
        check("rst_cmd_rdy", bus.cmd_rdy, 0);
        bus.cmd_UART = 16'h4003; bus.cmd_rdy_UART = 1'b1; #1;
        check("idle_cmd", bus.cmd, 16'h4003);
        check("idle_cmd_rdy", bus.cmd_rdy, 1);
        exp_q.push_back(16'h4003);
        bus.clr_cmd_rdy = 1'b1; #1;
        check("idle_clr_uart", bus.clr_cmd_rdy_UART, 1);
        tick();
        bus.clr_cmd_rdy = 1'b0; bus.cmd_rdy_UART = 1'b0;
        check("idle_stays_resp", bus.resp, 8'hA5);

        // single move, index 0 = 8'h01
        pulse_start();
        check("v_rdy", bus.cmd_rdy, 1);
        check("v_cmd", bus.cmd, 16'h4002);
        check("v_resp", bus.resp, 8'h5A);
        check("v_idx", mv_indx, 0);
        exp_q.push_back(16'h4002);
        bus.clr_cmd_rdy = 1'b1; tick(); bus.clr_cmd_rdy = 1'b0;
        check("holdv_rdy", bus.cmd_rdy, 0);
        check("holdv_cmd", bus.cmd, 16'h4002);
        bus.send_resp = 1'b1; tick(); bus.send_resp = 1'b0;
        check("h_cmd", bus.cmd, 16'h5BF1);
        check("h_rdy", bus.cmd_rdy, 1);
        check("h_resp", bus.resp, 8'h5A);
        exp_q.push_back(16'h5BF1);
        bus.clr_cmd_rdy = 1'b1; tick(); bus.clr_cmd_rdy = 1'b0;
        check("holdh_resp", bus.resp, 8'h5A);
        bus.send_resp = 1'b1; tick(); bus.send_resp = 1'b0;

        // decode sweep over the remaining one-hot moves
        for (int i = 1; i < 8; i++) do_move(i);

        // protocol robustness at index 8 (VERT)
        check("rob_idx", mv_indx, 8);
        bus.send_resp = 1'b1; tick(); bus.send_resp = 1'b0;
        check("rob_early_send_rdy", bus.cmd_rdy, 1);
        check("rob_early_send_cmd", bus.cmd, exp_v(tbl[8]));
        pulse_start();
        check("rob_restart_idx", mv_indx, 8);
        check("rob_restart_cmd", bus.cmd, exp_v(tbl[8]));
        bus.cmd_UART = 16'h1234; bus.cmd_rdy_UART = 1'b1; #1;
        check("rob_uart_cmd", bus.cmd, exp_v(tbl[8]));
        exp_q.push_back(exp_v(tbl[8]));
        bus.clr_cmd_rdy = 1'b1; #1;
        check("rob_clr_uart", bus.clr_cmd_rdy_UART, 0);
        tick(); bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b1; tick(); bus.send_resp = 1'b0;
        bus.cmd_rdy_UART = 1'b0; bus.cmd_UART = 16'h0;
        check("rob_idx_after", mv_indx, 8);
        exp_q.push_back(exp_h(tbl[8]));
        leg();
        do_move(9);

        // asynchronous reset in HOLD_V at index 10
        check("pre_rst_idx", mv_indx, 10);
        exp_q.push_back(exp_v(tbl[10]));
        bus.clr_cmd_rdy = 1'b1; tick(); bus.clr_cmd_rdy = 1'b0;
        check("holdv10_rdy", bus.cmd_rdy, 0);
        #3 rst_n = 1'b0; #1;
        check("arst_idx", mv_indx, 0);
        check("arst_resp", bus.resp, 8'hA5);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stray = 0;
        repeat (6) begin tick(); if (bus.cmd_rdy) stray++; end
        check("no_replay", stray, 0);
        check("sb_drained_pre", exp_q.size(), 0);

        // full tour with the handshaking command-processor model
        hs_cnt = 0; rise_cnt = 0; idx_log.delete();
        tour_mode = 1'b1; cp_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            exp_q.push_back(exp_v(tbl[i]));
            exp_q.push_back(exp_h(tbl[i]));
        end
        pulse_start();
        n = 0;
        while (hs_cnt < 48 && n < 3000) begin tick(); n++; end
        check("tour_hs", hs_cnt, 48);
        check("final_resp", bus.resp, 8'hA5);
        check("final_idx", mv_indx, 23);
        check("final_rdy", bus.cmd_rdy, 0);
        repeat (5) tick();
        cp_en = 1'b0; tour_mode = 1'b0;
        check("tour_rises", rise_cnt, 48);
        check("end_idle_resp", bus.resp, 8'hA5);
        bus.clr_cmd_rdy = 1'b1; #1;
        check("end_idle_clr_uart", bus.clr_cmd_rdy_UART, 1);
        bus.clr_cmd_rdy = 1'b0;
        bad = 0;
        if (idx_log.size() != 24) bad++;
        else for (int i = 0; i < 24; i++) if (idx_log[i] != i) bad++;
        check("idx_steps", bad, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
